sequenciador_linha_envase: RTL and testbench

- Master controller for the bottling line. Sequences the three station FSMs (conveyor, filling, sealing) one bottle at a time, using 4-phase cmd/done handshakes.
- Owns the cork stock counter and generates the cork-shortage alarm that the sealing station consumes.
- Counts finished bottles and watches every handshake with a timeout.
- Sits between the board switches/LEDs and the station FSMs.

---
 rtl/sequenciador_linha_envase.sv | 156 +++++++++++++++
 tb/tb_sequenciador_linha_envase.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_linha_envase.sv
// Master sequencer for the bottling line: conveyor -> filler -> sealer, one bottle at a time, plus cork stock and watchdog.
// Latency: registered Moore outputs; each cmd_* rises one cycle after its state is entered; alarme_rolha is decoded from the stock register.
// Backpressure: 4-phase cmd/done per station; cork shortage parks the line in PAUSA, a silent station trips ERRO.
// Optional: define LOTE_EN to stop the line after LOTE_TAM bottles until liga is seen low.
module sequenciador_linha_envase #(
    parameter int ROLHAS_INIT    = 20,
    parameter int ROLHAS_MAX     = 50,
    parameter int TIMEOUT_CICLOS = 150000000,
    parameter int LOTE_TAM       = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       liga,
    input  logic       recarga,
    input  logic       esteira_ok,
    input  logic       enchimento_ok,
    input  logic       vedacao_ok,
    input  logic       decrementar_rolha,
    output logic       cmd_esteira,
    output logic       cmd_enchimento,
    output logic       cmd_vedacao,
    output logic       alarme_rolha,
    output logic [7:0] estoque_rolhas,
    output logic [7:0] garrafas_prontas,
    output logic       erro_timeout,
    output logic       lote_completo
);

    // Watchdog width: enough for TIMEOUT_CICLOS, never below 28 bits.
    localparam int WD_W_MIN = $clog2(TIMEOUT_CICLOS + 1);
    localparam int WD_W     = (WD_W_MIN > 28) ? WD_W_MIN : 28;
    // The count equals the number of cycles already spent in the state, so the
    // TIMEOUT_CICLOS-th cycle is the one where the counter shows TIMEOUT_CICLOS-1.
    localparam logic [WD_W-1:0] WD_ULTIMO = WD_W'(TIMEOUT_CICLOS - 1);

    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] ESTEIRA     = 4'd1;
    localparam logic [3:0] ESTEIRA_REL = 4'd2;
    localparam logic [3:0] ENCHER      = 4'd3;
    localparam logic [3:0] ENCHER_REL  = 4'd4;
    localparam logic [3:0] VEDAR       = 4'd5;
    localparam logic [3:0] VEDAR_REL   = 4'd6;
    localparam logic [3:0] PAUSA       = 4'd7;
    localparam logic [3:0] ERRO        = 4'd8;

    logic [3:0]      state;
    logic [3:0]      state_nxt;
    logic [WD_W-1:0] wd;
    logic            wd_ativo;
    logic            wd_lim;
    logic            fim_garrafa;
    logic            lote_fim;
    logic            lote_bloq;

    assign alarme_rolha = (estoque_rolhas == 8'd0);
    assign fim_garrafa  = (state == VEDAR_REL) && !vedacao_ok;
    assign wd_ativo     = (state == ESTEIRA) || (state == ESTEIRA_REL) ||
                          (state == ENCHER)  || (state == ENCHER_REL)  ||
                          (state == VEDAR)   || (state == VEDAR_REL);
    assign wd_lim       = (wd == WD_ULTIMO);

`ifdef LOTE_EN
    localparam logic [3:0] LOTE_ULT = 4'(LOTE_TAM - 1);
    logic [3:0] lote_cnt;

    assign lote_fim  = fim_garrafa && (lote_cnt == LOTE_ULT);
    assign lote_bloq = lote_completo;

    // Batch counter: counts finished bottles, latches completion, rearmed by liga low while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lote_cnt      <= 4'd0;
            lote_completo <= 1'b0;
        end else if ((state == IDLE) && lote_completo && !liga) begin
            lote_cnt      <= 4'd0;
            lote_completo <= 1'b0;
        end else if (fim_garrafa) begin
            lote_cnt <= lote_cnt + 4'd1;
            if (lote_fim)
                lote_completo <= 1'b1;
        end
    end
`else
    // No batch limit: the line runs for as long as liga is high.
    assign lote_fim      = 1'b0;
    assign lote_bloq     = 1'b0;
    assign lote_completo = 1'b0;
`endif

    // Next state: bottle sequence; a station answering on the last allowed cycle beats the watchdog
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (liga && !alarme_rolha && !lote_bloq) state_nxt = ESTEIRA;
            ESTEIRA:     if (esteira_ok)     state_nxt = ESTEIRA_REL;
            ESTEIRA_REL: if (!esteira_ok)    state_nxt = ENCHER;
            ENCHER:      if (enchimento_ok)  state_nxt = ENCHER_REL;
            ENCHER_REL:  if (!enchimento_ok) state_nxt = VEDAR;
            VEDAR: begin
                if (vedacao_ok)        state_nxt = VEDAR_REL;
                else if (alarme_rolha) state_nxt = PAUSA;
            end
            VEDAR_REL:   if (!vedacao_ok) state_nxt = (liga && !lote_fim) ? ESTEIRA : IDLE;
            PAUSA:       if (!alarme_rolha) state_nxt = VEDAR;
            ERRO:        if (!liga) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
        if (wd_ativo && wd_lim && (state_nxt == state))
            state_nxt = ERRO;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Watchdog: restarts on every state change, runs only while a handshake is pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   wd <= '0;
        else if (state_nxt != state) wd <= '0;
        else if (wd_ativo)           wd <= wd + 1'b1;
    end

    // Registered Moore outputs, one cycle behind the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_esteira    <= 1'b0;
            cmd_enchimento <= 1'b0;
            cmd_vedacao    <= 1'b0;
            erro_timeout   <= 1'b0;
        end else begin
            cmd_esteira    <= (state == ESTEIRA);
            cmd_enchimento <= (state == ENCHER);
            cmd_vedacao    <= (state == VEDAR);
            erro_timeout   <= (state == ERRO);
        end
    end

    // Cork stock: refill beats a simultaneous decrement; decrement saturates at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            estoque_rolhas <= 8'(ROLHAS_INIT);
        else if (recarga)
            estoque_rolhas <= 8'(ROLHAS_MAX);
        else if (decrementar_rolha && (estoque_rolhas != 8'd0))
            estoque_rolhas <= estoque_rolhas - 8'd1;
    end

    // Finished-bottle counter, bumped when the sealer releases its done; wraps at 255
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            garrafas_prontas <= 8'd0;
        else if (fim_garrafa) garrafas_prontas <= garrafas_prontas + 8'd1;
    end

endmodule

// File: tb/tb_sequenciador_linha_envase.sv
module tb_sequenciador_linha_envase;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       liga = 1'b0;
    logic       rec_man = 1'b0;
    logic       dec_man = 1'b0;
    logic       dec_st = 1'b0;
    logic [2:0] st_ok = 3'b000;
    logic       recarga;
    logic       decrementar_rolha;
    logic       cmd_esteira, cmd_enchimento, cmd_vedacao, alarme_rolha;
    logic [7:0] estoque_rolhas, garrafas_prontas;
    logic       erro_timeout, lote_completo;

    assign recarga           = rec_man;
    assign decrementar_rolha = dec_st | dec_man;

    sequenciador_linha_envase #(
        .ROLHAS_INIT(20), .ROLHAS_MAX(50), .TIMEOUT_CICLOS(100), .LOTE_TAM(2)
    ) dut (
        .clk(clk), .reset(reset), .liga(liga), .recarga(recarga),
        .esteira_ok(st_ok[0]), .enchimento_ok(st_ok[1]), .vedacao_ok(st_ok[2]),
        .decrementar_rolha(decrementar_rolha),
        .cmd_esteira(cmd_esteira), .cmd_enchimento(cmd_enchimento), .cmd_vedacao(cmd_vedacao),
        .alarme_rolha(alarme_rolha), .estoque_rolhas(estoque_rolhas),
        .garrafas_prontas(garrafas_prontas), .erro_timeout(erro_timeout),
        .lote_completo(lote_completo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nome, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    // Reference model state: cork stock and bottle count from the rules, station behaviour
    int         m_est = 20;
    logic [7:0] m_gar = 8'd0;
    bit         st_en[3] = '{1, 1, 1};
    bit         rnd = 0;
    int         st_cnt[3] = '{0, 0, 0};
    int         st_resp[3] = '{3, 3, 3};
    int         st_rel[3] = '{2, 2, 2};
    int         mon_last = -1;
    logic [2:0] c_prev = 3'b000;

    // Per-cycle: compare against the model, check cmd order, run the station responders
    initial begin
        logic [2:0] c;
        bit ok_ord;
        bit dec_now;
        forever begin
            @(negedge clk);
            c = {cmd_vedacao, cmd_enchimento, cmd_esteira};
            dec_st = 1'b0;
            if (!reset) begin
                chk("estoque_modelo", estoque_rolhas, m_est);
                chk("garrafas_modelo", garrafas_prontas, m_gar);
                chk("alarme_modelo", alarme_rolha, (m_est == 0));
                chk("cmd_exclusivo", ($countones(c) <= 1), 1);
                for (int i = 0; i < 3; i++) begin
                    if (c[i] && !c_prev[i]) begin
                        ok_ord = (i == 0) ? (mon_last < 0 || mon_last == 2) :
                                 (i == 1) ? (mon_last == 0) : (mon_last == 1 || mon_last == 2);
                        chk($sformatf("ordem_cmd%0d_apos_%0d", i, mon_last), ok_ord, 1);
                        mon_last = i;
                    end
                end
                if (erro_timeout) mon_last = -1;
                for (int i = 0; i < 3; i++) begin
                    if (!st_ok[i]) begin
                        // The sealer aborts silently while the cork stock is empty.
                        if (c[i] && st_en[i] && !(i == 2 && alarme_rolha)) begin
                            st_cnt[i]++;
                            if (st_cnt[i] >= st_resp[i]) begin
                                st_ok[i]  = 1'b1;
                                st_cnt[i] = 0;
                                st_rel[i] = rnd ? int'($urandom_range(1, 4)) : 2;
                                if (i == 2) dec_st = 1'b1;
                            end
                        end else st_cnt[i] = 0;
                    end else begin
                        if (!c[i]) begin
                            st_cnt[i]++;
                            if (st_cnt[i] >= st_rel[i]) begin
                                st_ok[i]   = 1'b0;
                                st_cnt[i]  = 0;
                                st_resp[i] = rnd ? int'($urandom_range(1, 6)) : 3;
                                if (i == 2) m_gar = m_gar + 8'd1;
                            end
                        end else st_cnt[i] = 0;
                    end
                end
                dec_now = dec_st | dec_man;
                if (rec_man)                 m_est = 50;
                else if (dec_now && m_est > 0) m_est = m_est - 1;
            end
            c_prev = c;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        m_est = 20;
        m_gar = 8'd0;
        st_ok = 3'b000;
        dec_st = 1'b0;
        mon_last = -1;
        for (int i = 0; i < 3; i++) begin
            st_cnt[i] = 0; st_resp[i] = 3; st_rel[i] = 2; st_en[i] = 1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        liga = 1'b0;
        assert_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_gar(input int alvo, input int lim);
        int n = 0;
        while (garrafas_prontas != alvo && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic rec;
        logic dec;
        int   reps;
        int   exp_est;
        logic exp_al;
    } vec_t;

    initial begin
        vec_t tab[9];
        int n;
        int bad;
        tab[0] = '{1'b0, 1'b1, 1, 19, 1'b0};
        tab[1] = '{1'b1, 1'b1, 1, 50, 1'b0};
        tab[2] = '{1'b0, 1'b0, 3, 50, 1'b0};
        tab[3] = '{1'b0, 1'b1, 49, 1, 1'b0};
        tab[4] = '{1'b0, 1'b1, 1, 0, 1'b1};
        tab[5] = '{1'b0, 1'b1, 3, 0, 1'b1};
        tab[6] = '{1'b1, 1'b0, 1, 50, 1'b0};
        tab[7] = '{1'b0, 1'b1, 40, 10, 1'b0};
        tab[8] = '{1'b1, 1'b1, 1, 50, 1'b0};

        assert_reset();
        #12;
        chk("rst_cmd_esteira", cmd_esteira, 0);
        chk("rst_cmd_enchimento", cmd_enchimento, 0);
        chk("rst_cmd_vedacao", cmd_vedacao, 0);
        chk("rst_erro", erro_timeout, 0);
        chk("rst_garrafas", garrafas_prontas, 0);
        chk("rst_estoque", estoque_rolhas, 20);
        chk("rst_lote", lote_completo, 0);
        chk("rst_alarme", alarme_rolha, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Cork counter table: refill, saturation, refill-wins
        foreach (tab[k]) begin
            tick();
            rec_man = tab[k].rec;
            dec_man = tab[k].dec;
            repeat (tab[k].reps) tick();
            rec_man = 1'b0;
            dec_man = 1'b0;
            @(negedge clk);
            chk($sformatf("tab%0d_estoque", k), estoque_rolhas, tab[k].exp_est);
            chk($sformatf("tab%0d_alarme", k), alarme_rolha, tab[k].exp_al);
        end

        // Timeout: conveyor never answers
        do_reset();
        st_en[0] = 0;
        tick();
        liga = 1'b1;
        n = 0;
        while (!cmd_esteira && n < 20) begin @(negedge clk); n++; end
        chk("to_cmd_esteira_sobe", cmd_esteira, 1);
        n = 0;
        while (cmd_esteira && n < 300) begin @(negedge clk); n++; end
        chk("to_ciclos_cmd_alto", n, 100);
        chk("to_erro_junto", erro_timeout, 1);
        repeat (5) @(negedge clk);
        chk("to_erro_mantido", erro_timeout, 1);
        chk("to_cmd_baixo", cmd_esteira, 0);
        tick();
        liga = 1'b0;
        n = 0;
        while (erro_timeout && n < 5) begin @(negedge clk); n++; end
        chk("to_erro_limpo", erro_timeout, 0);
        bad = 0;
        repeat (10) begin @(negedge clk); if (cmd_esteira) bad++; end
        chk("to_idle_sem_cmd", bad, 0);
        st_en[0] = 1;

`ifdef LOTE_EN
        // Batch of 2 with liga held high
        do_reset();
        tick();
        liga = 1'b1;
        wait_gar(2, 300);
        chk("lote_garrafas", garrafas_prontas, 2);
        chk("lote_completo_set", lote_completo, 1);
        bad = 0;
        repeat (20) begin @(negedge clk); if (cmd_esteira) bad++; end
        chk("lote_parado", bad, 0);
        tick();
        liga = 1'b0;
        tick();
        liga = 1'b1;
        n = 0;
        while (lote_completo && n < 5) begin @(negedge clk); n++; end
        chk("lote_completo_limpo", lote_completo, 0);
        n = 0;
        while (!cmd_esteira && n < 20) begin @(negedge clk); n++; end
        chk("lote_retoma", cmd_esteira, 1);
`else
        // Normal cycle: three bottles, then stop while filling
        do_reset();
        tick();
        liga = 1'b1;
        wait_gar(3, 500);
        chk("normal_garrafas", garrafas_prontas, 3);
        chk("normal_estoque", estoque_rolhas, 17);
        n = 0;
        while (!cmd_enchimento && n < 100) begin @(negedge clk); n++; end
        chk("stop_em_encher", cmd_enchimento, 1);
        tick();
        liga = 1'b0;
        wait_gar(4, 200);
        chk("stop_garrafa_termina", garrafas_prontas, 4);
        bad = 0;
        repeat (30) begin @(negedge clk); if (cmd_esteira) bad++; end
        chk("stop_sem_esteira", bad, 0);
        chk("stop_garrafas_fixo", garrafas_prontas, 4);

        // Cork shortage: stock 1, bottle 2 reaches the sealer with no cork
        do_reset();
        tick();
        dec_man = 1'b1;
        repeat (19) tick();
        dec_man = 1'b0;
        @(negedge clk);
        chk("falta_estoque_1", estoque_rolhas, 1);
        tick();
        liga = 1'b1;
        wait_gar(1, 300);
        n = 0;
        while (!cmd_vedacao && n < 300) begin @(negedge clk); n++; end
        chk("falta_vedar_cmd", cmd_vedacao, 1);
        chk("falta_alarme", alarme_rolha, 1);
        @(negedge clk);
        chk("falta_cmd_cai", cmd_vedacao, 0);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cmd_esteira || cmd_enchimento || cmd_vedacao || erro_timeout) bad++;
        end
        chk("falta_pausa_congelada", bad, 0);
        chk("falta_garrafas", garrafas_prontas, 1);
        tick();
        rec_man = 1'b1;
        tick();
        rec_man = 1'b0;
        @(negedge clk);
        chk("falta_recarga_estoque", estoque_rolhas, 50);
        n = 0;
        while (!cmd_vedacao && n < 3) begin @(negedge clk); n++; end
        chk("falta_vedar_retoma", cmd_vedacao, 1);
        wait_gar(2, 200);
        chk("falta_garrafa2", garrafas_prontas, 2);
        chk("falta_estoque_49", estoque_rolhas, 49);

        // Reset while sealing bottle 3
        do_reset();
        tick();
        liga = 1'b1;
        wait_gar(2, 300);
        n = 0;
        while (!cmd_vedacao && n < 100) begin @(negedge clk); n++; end
        chk("rstv_em_vedar", cmd_vedacao, 1);
        chk("rstv_estoque_antes", estoque_rolhas, 18);
        @(posedge clk);
        #2;
        assert_reset();
        #1;
        chk("rstv_cmd_vedacao", cmd_vedacao, 0);
        chk("rstv_cmd_esteira", cmd_esteira, 0);
        chk("rstv_garrafas", garrafas_prontas, 0);
        chk("rstv_estoque", estoque_rolhas, 20);
        chk("rstv_erro", erro_timeout, 0);
        chk("rstv_alarme", alarme_rolha, 0);
        liga = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Random: station delays, liga toggles, refills and stray decrements vs the model
        do_reset();
        rnd = 1;
        tick();
        liga = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            tick();
            rec_man = ($urandom_range(0, 199) == 0);
            dec_man = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) liga = !liga;
        end
        tick();
        rec_man = 1'b0;
        dec_man = 1'b0;
        rnd = 0;
        @(negedge clk);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
